// File: rtl/alu_result_tx_if.sv
// Bus between the result formatter, its requester and the UART transmitter.
// The master side drives start/result and the UART's tx_done; the slave is the formatter.
interface alu_result_tx_if #(
    parameter int unsigned NUM_NIBBLES = 8
);
    localparam int unsigned RES_W = 4 * NUM_NIBBLES;

    logic             start;
    logic [RES_W-1:0] result;
    logic             tx_done;
    logic [7:0]       d_out;
    logic             tx_start;
    logic             busy;
    logic             done;

    modport master (
        output start, result, tx_done,
        input  d_out, tx_start, busy, done
    );

    modport slave (
        input  start, result, tx_done,
        output d_out, tx_start, busy, done
    );
endinterface

// File: rtl/alu_result_tx.sv
// Sends a latched ALU result to the UART as uppercase ASCII hex digits,
// optionally skipping leading zeros and appending a terminator byte.
module alu_result_tx #(
    parameter int unsigned NUM_NIBBLES    = 8,
    parameter bit          SUPPRESS_ZEROS = 1'b1,
    parameter bit          USE_TERM       = 1'b1,
    parameter logic [7:0]  TERMINATOR     = 8'h0A
) (
    input logic          clk,
    input logic          reset,
    alu_result_tx_if.slave bus
);
    localparam int unsigned RES_W = 4 * NUM_NIBBLES;
    localparam int unsigned CNT_W = (NUM_NIBBLES > 1) ? $clog2(NUM_NIBBLES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        SEND,
        WAIT,
        TERM,
        TWAIT,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [RES_W-1:0] sr;
    logic [RES_W-1:0] sr_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             tx_done_q;
    logic             tx_edge_c;

    logic [7:0]       d_out;
    logic [7:0]       d_out_next;
    logic             tx_start;
    logic             tx_start_next;
    logic             busy;
    logic             busy_next;
    logic             done;
    logic             done_next;

    function automatic logic [7:0] to_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // Only a fresh rising edge of the UART's done level advances the transfer.
    assign tx_edge_c = bus.tx_done & ~tx_done_q;

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            sr        <= '0;
            cnt       <= '0;
            tx_done_q <= 1'b0;
            d_out     <= 8'h00;
            tx_start  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            sr        <= sr_next;
            cnt       <= cnt_next;
            tx_done_q <= bus.tx_done;
            d_out     <= d_out_next;
            tx_start  <= tx_start_next;
            busy      <= busy_next;
            done      <= done_next;
        end
    end

    // Next state plus shift register / digit counter updates.
    always_comb begin
        state_next = state;
        sr_next    = sr;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    sr_next    = bus.result;
                    cnt_next   = CNT_W'(NUM_NIBBLES - 1);
                    state_next = SCAN;
                end
            end
            SCAN: begin
                if (SUPPRESS_ZEROS && (sr[RES_W-1 -: 4] == 4'h0) && (cnt != '0)) begin
                    sr_next  = sr << 4;
                    cnt_next = cnt - CNT_W'(1);
                end else begin
                    state_next = SEND;
                end
            end
            SEND: state_next = WAIT;
            WAIT: begin
                if (tx_edge_c) begin
                    if (cnt == '0) begin
                        state_next = USE_TERM ? TERM : DONE;
                    end else begin
                        sr_next    = sr << 4;
                        cnt_next   = cnt - CNT_W'(1);
                        state_next = SEND;
                    end
                end
            end
            TERM:  state_next = TWAIT;
            TWAIT: begin
                if (tx_edge_c) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Moore outputs decoded from the upcoming state so they register in step with it.
    always_comb begin
        d_out_next    = d_out;
        tx_start_next = 1'b0;
        busy_next     = (state_next != IDLE);
        done_next     = (state_next == DONE);
        case (state_next)
            SEND: begin
                d_out_next    = to_ascii(sr_next[RES_W-1 -: 4]);
                tx_start_next = 1'b1;
            end
            TERM: begin
                d_out_next    = TERMINATOR;
                tx_start_next = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.d_out    = d_out;
    assign bus.tx_start = tx_start;
    assign bus.busy     = busy;
    assign bus.done     = done;

endmodule

// File: tb/tb_alu_result_tx.sv
// Randomised bench for alu_result_tx: a default instance and one without
// zero suppression or terminator, each fed by a simple UART TX model.
module tb_alu_result_tx;

    logic        clk = 1'b0;
    logic        reset;
    int unsigned cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_result_tx_if #(.NUM_NIBBLES(8)) a_bus ();
    alu_result_tx_if #(.NUM_NIBBLES(8)) b_bus ();

    alu_result_tx #(
        .NUM_NIBBLES(8), .SUPPRESS_ZEROS(1'b1), .USE_TERM(1'b1), .TERMINATOR(8'h0A)
    ) dut_a (
        .clk(clk), .reset(reset), .bus(a_bus)
    );

    alu_result_tx #(
        .NUM_NIBBLES(8), .SUPPRESS_ZEROS(1'b0), .USE_TERM(1'b0), .TERMINATOR(8'h0A)
    ) dut_b (
        .clk(clk), .reset(reset), .bus(b_bus)
    );

    logic [1:0]  start_r;
    logic [31:0] result_r [2];
    logic [1:0]  tx_done_r;
    logic [1:0]  man;
    logic [1:0]  auto_tx;
    int          tx_delay [2];

    assign a_bus.start   = start_r[0];
    assign b_bus.start   = start_r[1];
    assign a_bus.result  = result_r[0];
    assign b_bus.result  = result_r[1];
    assign a_bus.tx_done = tx_done_r[0] | man[0];
    assign b_bus.tx_done = tx_done_r[1] | man[1];

    wire [1:0] tx_start_w = {b_bus.tx_start, a_bus.tx_start};
    wire [1:0] busy_w     = {b_bus.busy, a_bus.busy};
    wire [1:0] done_w     = {b_bus.done, a_bus.done};
    wire [1:0] txd_w      = {b_bus.tx_done, a_bus.tx_done};
    wire [7:0] d_out_w [2];
    assign d_out_w[0] = a_bus.d_out;
    assign d_out_w[1] = b_bus.d_out;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Captured traffic, written only by the monitor process.
    logic [7:0]  got    [2][1024];
    int unsigned cyc_at [2][1024];
    int          got_n  [2];
    int          done_n [2];
    int          cd     [2];
    logic [7:0]  held   [2];
    logic [1:0]  inflight;
    logic [1:0]  prev_done;
    logic [1:0]  edge_valid;
    int unsigned edge_cyc [2];
    int          hold_bad = 0;
    int          gap_bad  = 0;

    // UART TX model (pulse tx_done a set delay after tx_start) and byte monitor.
    initial begin
        for (int g = 0; g < 2; g++) begin
            got_n[g] = 0; done_n[g] = 0; cd[g] = 0; held[g] = 8'h00; edge_cyc[g] = 0;
        end
        tx_done_r = '0; inflight = '0; prev_done = '0; edge_valid = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int g = 0; g < 2; g++) begin
                if (tx_done_r[g]) tx_done_r[g] = 1'b0;
                if (cd[g] > 0) begin
                    cd[g]--;
                    if (cd[g] == 0) tx_done_r[g] = 1'b1;
                end
            end
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                if (!reset) begin
                    inflight[g]   = 1'b0;
                    edge_valid[g] = 1'b0;
                end else begin
                    if (tx_start_w[g]) begin
                        got[g][got_n[g] % 1024]    = d_out_w[g];
                        cyc_at[g][got_n[g] % 1024] = cyc;
                        got_n[g]++;
                        held[g]     = d_out_w[g];
                        inflight[g] = 1'b1;
                        if (edge_valid[g] && (cyc - edge_cyc[g] != 1)) gap_bad++;
                        edge_valid[g] = 1'b0;
                        if (auto_tx[g]) cd[g] = tx_delay[g];
                    end else if (inflight[g]) begin
                        if (txd_w[g] && !prev_done[g]) begin
                            inflight[g]   = 1'b0;
                            edge_valid[g] = 1'b1;
                            edge_cyc[g]   = cyc;
                        end else if (d_out_w[g] !== held[g]) begin
                            hold_bad++;
                        end
                    end
                    if (done_w[g]) begin
                        done_n[g]++;
                        edge_valid[g] = 1'b0;
                    end
                end
                prev_done[g] = txd_w[g];
            end
        end
    end

    // Reference: hex text of the result, from plain digit arithmetic.
    logic [7:0] exp_b [16];
    int         exp_n;
    int         exp_z;

    task automatic model(input logic [31:0] r, input bit sz, input bit ut);
        int top;
        int d;
        longint unsigned v;
        v   = 64'(r);
        top = 7;
        if (sz) begin
            top = 0;
            for (int i = 1; i < 8; i++)
                if ((v / (64'd1 << (4 * i))) % 16 != 0) top = i;
        end
        exp_z = 7 - top;
        exp_n = 0;
        for (int i = top; i >= 0; i--) begin
            d = int'((v / (64'd1 << (4 * i))) % 16);
            exp_b[exp_n] = (d < 10) ? 8'(48 + d) : 8'(65 + d - 10);
            exp_n++;
        end
        if (ut) begin
            exp_b[exp_n] = 8'h0A;
            exp_n++;
        end
    endtask

    task automatic wait_bytes(input int s, input int target, input string tag);
        for (int n = 0; n < 300 && got_n[s] < target; n++) @(negedge clk);
        if (got_n[s] < target) check_eq({tag, ":timeout"}, 32'(got_n[s]), 32'(target));
    endtask

    task automatic pulse_start(input int s, input logic [31:0] r, output int unsigned t0);
        @(posedge clk);
        #1;
        result_r[s] = r;
        start_r[s]  = 1'b1;
        t0 = cyc;
        @(posedge clk);
        #1;
        start_r[s]  = 1'b0;
        result_r[s] = $urandom;
    endtask

    task automatic run(input int s, input logic [31:0] r, input bit sz, input bit ut,
                       input bit poke, input string tag);
        int          base;
        int          dbase;
        int unsigned t0;
        bit          poked;
        model(r, sz, ut);
        base  = got_n[s];
        dbase = done_n[s];
        poked = 1'b0;
        pulse_start(s, r, t0);
        for (int n = 0; n < 4000 && done_n[s] == dbase; n++) begin
            @(negedge clk);
            if (poke && !poked && got_n[s] >= base + 2) begin
                #1;
                start_r[s]  = 1'b1;
                result_r[s] = 32'hFFFF_FFFF;
                @(posedge clk);
                #1;
                start_r[s] = 1'b0;
                poked = 1'b1;
            end
        end
        repeat (6) @(negedge clk);
        check_eq({tag, ":bytes"}, 32'(got_n[s] - base), 32'(exp_n));
        for (int i = 0; i < exp_n && i < got_n[s] - base; i++)
            check_eq($sformatf("%s:byte%0d", tag, i), 32'(got[s][(base + i) % 1024]), 32'(exp_b[i]));
        check_eq({tag, ":done"}, 32'(done_n[s] - dbase), 32'd1);
        check_eq({tag, ":busy"}, 32'(busy_w[s]), 32'd0);
        if (got_n[s] > base)
            check_eq({tag, ":latency"}, 32'(cyc_at[s][base % 1024] - t0), 32'(2 + exp_z));
    endtask

    initial begin
        int          base;
        int          dbase;
        int unsigned t0;
        reset       = 1'b0;
        start_r     = '0;
        result_r[0] = '0;
        result_r[1] = '0;
        man         = '0;
        auto_tx     = 2'b11;
        tx_delay[0] = 10;
        tx_delay[1] = 10;

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check_eq($sformatf("rst%0d:d_out", s), 32'(d_out_w[s]), 32'h00);
            check_eq($sformatf("rst%0d:tx_start", s), 32'(tx_start_w[s]), 32'd0);
            check_eq($sformatf("rst%0d:busy", s), 32'(busy_w[s]), 32'd0);
            check_eq($sformatf("rst%0d:done", s), 32'(done_w[s]), 32'd0);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);

        run(0, 32'h0000_001A, 1'b1, 1'b1, 1'b0, "h1a");
        run(0, 32'h0000_0000, 1'b1, 1'b1, 1'b0, "zero");
        run(0, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0, "deadbeef");
        run(1, 32'h0000_0005, 1'b0, 1'b0, 1'b0, "nosup5");
        run(0, 32'h0000_0C3D, 1'b1, 1'b1, 1'b1, "poke");

        // tx_done held high across a byte boundary.
        auto_tx[0] = 1'b0;
        model(32'h0000_001A, 1'b1, 1'b1);
        base  = got_n[0];
        dbase = done_n[0];
        pulse_start(0, 32'h0000_001A, t0);
        wait_bytes(0, base + 1, "held:b1");
        repeat (3) @(posedge clk);
        #1 man[0] = 1'b1;
        wait_bytes(0, base + 2, "held:b2");
        repeat (8) @(posedge clk);
        #1;
        check_eq("held:stall", 32'(got_n[0] - base), 32'd2);
        man[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1 man[0] = 1'b1;
        wait_bytes(0, base + 3, "held:b3");
        repeat (3) @(posedge clk);
        #1 man[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1 man[0] = 1'b1;
        repeat (4) @(posedge clk);
        #1 man[0] = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("held:bytes_vs_edges", 32'(got_n[0] - base), 32'd3);
        for (int i = 0; i < 3 && i < got_n[0] - base; i++)
            check_eq($sformatf("held:byte%0d", i), 32'(got[0][(base + i) % 1024]), 32'(exp_b[i]));
        check_eq("held:done", 32'(done_n[0] - dbase), 32'd1);
        auto_tx[0] = 1'b1;

        // Reset in the middle of the third byte.
        tx_delay[0] = 10;
        base = got_n[0];
        pulse_start(0, 32'hDEAD_BEEF, t0);
        wait_bytes(0, base + 3, "rstmid:b3");
        repeat (4) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check_eq("rstmid:tx_start", 32'(tx_start_w[0]), 32'd0);
        check_eq("rstmid:busy", 32'(busy_w[0]), 32'd0);
        check_eq("rstmid:d_out", 32'(d_out_w[0]), 32'h00);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (20) @(negedge clk);
        check_eq("rstmid:quiet", 32'(got_n[0] - base), 32'd3);
        run(0, 32'h0000_0001, 1'b1, 1'b1, 1'b0, "after_rst");

        for (int i = 0; i < 8; i++) begin
            tx_delay[0] = int'($urandom_range(1, 12));
            run(0, $urandom >> $urandom_range(0, 31), 1'b1, 1'b1, 1'b0, $sformatf("rnd_a%0d", i));
            tx_delay[1] = int'($urandom_range(1, 12));
            run(1, $urandom, 1'b0, 1'b0, 1'b0, $sformatf("rnd_b%0d", i));
        end

        check_eq("d_out_hold", 32'(hold_bad), 32'd0);
        check_eq("tx_start_gap", 32'(gap_bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
